// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, default datapath sizing and
// small opcode helpers used by the shift execute stage and its core.
package alu_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int SW_DEFAULT    = 5;
  localparam int CNT_W_DEFAULT = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Reserved opcode: produces a zero result and raises the error flag.
  function automatic logic op_is_reserved(input logic [1:0] op);
    return (op == OP_RSV);
  endfunction

endpackage

// File: rtl/shift_exec_stage_shifter_core.sv
// Combinational barrel shifter. Right shifts run directly through a
// log2(N)-stage barrel; left shifts reverse the operand, shift right with
// zero fill and reverse the result back, so only one barrel is needed.
module shifter_core
  import alu_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int SW = SW_DEFAULT
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] amt,
  input  logic [1:0]    op,
  output logic [N-1:0]  z
);

  localparam logic [N-1:0] ONES = '1;

  logic [N-1:0] w_src;
  logic [N-1:0] w_shr;
  logic         w_fill;

  // Arithmetic right shift replicates the sign bit; everything else zero-fills.
  assign w_fill = (op == OP_SRA) & a[N-1];

  // Select the barrel input: bit-reversed operand for left shifts.
  always_comb begin
    w_src = a;
    if (op == OP_SLL) begin
      for (int i = 0; i < N; i++) begin
        w_src[i] = a[N-1-i];
      end
    end
  end

  // Log-stage right barrel: stage s shifts by 2**s when amt[s] is set.
  always_comb begin
    w_shr = w_src;
    for (int s = 0; s < SW; s++) begin
      if (amt[s]) begin
        w_shr = (w_shr >> (1 << s)) | ({N{w_fill}} & ~(ONES >> (1 << s)));
      end
    end
  end

  // Undo the reversal for left shifts; reserved opcode yields zero.
  always_comb begin
    z = '0;
    case (op)
      OP_SLL: begin
        for (int i = 0; i < N; i++) begin
          z[i] = w_shr[N-1-i];
        end
      end
      OP_SRL:  z = w_shr;
      OP_SRA:  z = w_shr;
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined execute wrapper around the shift core.
// S1 holds the accepted operands, S2 holds the shifted result and flags.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; out_valid is a pure register output, never a function of
// out_ready, and S2 contents hold while out_valid is high and out_ready low.
module shift_exec_stage
  import alu_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SW    = SW_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  logic             r_init;
  logic             r_s1_valid;
  logic [N-1:0]     r_s1_a;
  logic [SW-1:0]    r_s1_amt;
  logic [1:0]       r_s1_op;
  logic             r_s2_valid;
  logic [N-1:0]     r_s2_data;
  logic             r_s2_zero;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [N-1:0]     w_z;
  logic             w_unused_b;

  // Only the low SW bits of the shift operand are meaningful.
  assign w_unused_b = ^in_b[N-1:SW];

  assign w_s2_load  = !r_s2_valid | out_ready;
  assign w_in_ready = r_init & (!r_s1_valid | w_s2_load);
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_s2_valid & out_ready;

  shifter_core #(
    .N  (N),
    .SW (SW)
  ) u_shifter (
    .a   (r_s1_a),
    .amt (r_s1_amt),
    .op  (r_s1_op),
    .z   (w_z)
  );

  // Ready stays low through reset and rises after the first clean edge.
  always_ff @(posedge clk) begin
    if (rst) r_init <= 1'b0;
    else     r_init <= 1'b1;
  end

  // Stage 1: capture operands on accept, drain when stage 2 takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_amt   <= '0;
      r_s1_op    <= OP_SLL;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_a;
      r_s1_amt   <= in_b[SW-1:0];
      r_s1_op    <= in_op;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: register shift result and flags whenever the slot can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_z;
        r_s2_zero <= (w_z == '0);
        r_s2_err  <= op_is_reserved(r_s1_op);
      end
    end
  end

  // Completed-operation counter; wraps freely.
  always_ff @(posedge clk) begin
    if (rst)             r_op_count <= '0;
    else if (w_out_fire) r_op_count <= r_op_count + CNT_W'(1);
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_zero  = r_s2_zero;
  assign out_err   = r_s2_err;
  assign op_count  = r_op_count;

endmodule
